// File: rtl/cache_pkg.sv
// Shared geometry, tag-entry layout and FSM encoding for the 2-way data cache.
package cache_pkg;

  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned BLOCK_BITS = 128;
  localparam int unsigned TAG_BITS   = 20;
  localparam int unsigned ENTRY_BITS = 23;

  // Entry layout: [22] valid, [21] used, [20] dirty, [19:0] tag.
  typedef struct packed {
    logic                valid;
    logic                used;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } tag_entry_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_REFILL    = 3'd3;
  localparam logic [2:0] ST_RESPOND   = 3'd4;

  function automatic logic [WORD_BITS-1:0] get_word(input logic [BLOCK_BITS-1:0] blk,
                                                    input logic [1:0]            sel);
    return blk[{sel, 5'd0} +: WORD_BITS];
  endfunction

  function automatic logic [BLOCK_BITS-1:0] merge_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [1:0]            sel,
                                                       input logic [WORD_BITS-1:0]  word);
    logic [BLOCK_BITS-1:0] res;
    res = blk;
    res[{sel, 5'd0} +: WORD_BITS] = word;
    return res;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Chooses the replacement way for a miss: first invalid way, else the not-recently-used one.
module dcache_victim_sel
  import cache_pkg::*;
(
  input  logic [ENTRY_BITS-1:0] i_tag0,
  input  logic [ENTRY_BITS-1:0] i_tag1,
  output logic                  o_way,
  output logic                  o_dirty,
  output logic [TAG_BITS-1:0]   o_tag
);

  tag_entry_t w_t0;
  tag_entry_t w_t1;
  tag_entry_t w_victim;

  assign w_t0 = i_tag0;
  assign w_t1 = i_tag1;

  always_comb begin
    if (!w_t0.valid) begin
      o_way = 1'b0;
    end else if (!w_t1.valid) begin
      o_way = 1'b1;
    end else begin
      // Equal used bits fall back to way 0.
      o_way = w_t0.used & ~w_t1.used;
    end
    w_victim = o_way ? w_t1 : w_t0;
    o_dirty  = w_victim.valid & w_victim.dirty;
    o_tag    = w_victim.tag;
  end

endmodule

// File: rtl/dcache_controller.sv
// Blocking 2-way write-back data cache controller driving external tag/data RAMs.
module dcache_controller
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BIT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [INDEX_BIT-1:0]  ram_index,
  output logic [1:0]            tag_we,
  output logic [ENTRY_BITS-1:0] tag0_wdata,
  output logic [ENTRY_BITS-1:0] tag1_wdata,
  input  logic [ENTRY_BITS-1:0] tag0_rdata,
  input  logic [ENTRY_BITS-1:0] tag1_rdata,
  output logic [1:0]            data_we,
  output logic [BLOCK_BITS-1:0] data_wdata,
  input  logic [BLOCK_BITS-1:0] data0_rdata,
  input  logic [BLOCK_BITS-1:0] data1_rdata
);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_we;
  tag_entry_t            r_tag0;
  tag_entry_t            r_tag1;
  logic                  r_vway;
  logic [TAG_BITS-1:0]   r_vtag;
  logic [BLOCK_BITS-1:0] r_vdata;
  logic [BLOCK_BITS-1:0] r_block;

  tag_entry_t            w_tag0;
  tag_entry_t            w_tag1;
  tag_entry_t            w_e0;
  tag_entry_t            w_e1;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic [INDEX_BIT-1:0]  w_req_idx;
  logic [1:0]            w_req_word;
  logic                  w_hit0;
  logic                  w_hit;
  logic                  w_hit_way;
  logic [BLOCK_BITS-1:0] w_hit_blk;
  logic [BLOCK_BITS-1:0] w_fill;
  logic                  w_vway;
  logic                  w_vdirty;
  logic [TAG_BITS-1:0]   w_vtag;

  assign w_tag0     = tag0_rdata;
  assign w_tag1     = tag1_rdata;
  assign w_req_tag  = r_addr[31:32-TAG_BITS];
  assign w_req_idx  = r_addr[INDEX_BIT+1:2];
  assign w_req_word = r_addr[1:0];
  assign w_hit0     = w_tag0.valid && (w_tag0.tag == w_req_tag);
  assign w_hit      = w_hit0 || (w_tag1.valid && (w_tag1.tag == w_req_tag));
  assign w_hit_way  = ~w_hit0;
  assign w_hit_blk  = w_hit_way ? data1_rdata : data0_rdata;
  assign w_fill     = r_we ? merge_word(mem_rdata, w_req_word, r_wdata) : mem_rdata;

  dcache_victim_sel u_victim_sel (
    .i_tag0  (tag0_rdata),
    .i_tag1  (tag1_rdata),
    .o_way   (w_vway),
    .o_dirty (w_vdirty),
    .o_tag   (w_vtag)
  );

  // The RAMs register their address, so the new index must be presented in the accept cycle.
  assign ram_index = rst ? '0 :
                     ((r_state == ST_IDLE) && cpu_req) ? cpu_addr[INDEX_BIT+1:2] : w_req_idx;
  assign tag0_wdata = w_e0;
  assign tag1_wdata = w_e1;

  always_comb begin
    w_next     = r_state;
    cpu_done   = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    tag_we     = 2'b00;
    w_e0       = w_tag0;
    w_e1       = w_tag1;
    data_we    = 2'b00;
    data_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          cpu_done  = 1'b1;
          cpu_rdata = get_word(w_hit_blk, w_req_word);
          tag_we    = 2'b11;
          w_e0.used = ~w_hit_way;
          w_e1.used = w_hit_way;
          if (r_we) begin
            if (w_hit_way) w_e1.dirty = 1'b1;
            else           w_e0.dirty = 1'b1;
            data_we    = w_hit_way ? 2'b10 : 2'b01;
            data_wdata = merge_word(w_hit_blk, w_req_word, r_wdata);
          end
          w_next = ST_IDLE;
        end else begin
          w_next = w_vdirty ? ST_WRITEBACK : ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_vtag, w_req_idx, 2'b00};
        mem_wdata = r_vdata;
        if (mem_ack) w_next = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[31:2], 2'b00};
        if (mem_ack) begin
          tag_we    = 2'b11;
          w_e0      = r_tag0;
          w_e1      = r_tag1;
          w_e0.used = 1'b0;
          w_e1.used = 1'b0;
          if (r_vway) w_e1 = {1'b1, 1'b1, r_we, w_req_tag};
          else        w_e0 = {1'b1, 1'b1, r_we, w_req_tag};
          data_we    = r_vway ? 2'b10 : 2'b01;
          data_wdata = w_fill;
          w_next     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        cpu_done  = 1'b1;
        cpu_rdata = get_word(r_block, w_req_word);
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset wins combinationally so an ack coinciding with reset cannot write the RAMs.
    if (rst) begin
      w_next    = ST_IDLE;
      cpu_done  = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      tag_we    = 2'b00;
      data_we   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_tag0  <= '0;
      r_tag1  <= '0;
      r_vway  <= 1'b0;
      r_vtag  <= '0;
      r_vdata <= '0;
      r_block <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && cpu_req) begin
        r_addr  <= cpu_addr;
        r_we    <= cpu_we;
        r_wdata <= cpu_wdata;
      end
      if (r_state == ST_LOOKUP) begin
        r_tag0  <= w_tag0;
        r_tag1  <= w_tag1;
        r_vway  <= w_vway;
        r_vtag  <= w_vtag;
        r_vdata <= w_vway ? data1_rdata : data0_rdata;
      end
      if ((r_state == ST_REFILL) && mem_ack) r_block <= w_fill;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Random-access bench: RAM/memory models around the controller plus an architectural cache model.
module tb_dcache_controller;

  localparam int unsigned IB = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_done;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [IB-1:0] ram_index;
  logic [1:0]   tag_we;
  logic [1:0]   data_we;
  logic [22:0]  tag0_wdata, tag1_wdata, tag0_rdata, tag1_rdata;
  logic [127:0] data_wdata, data0_rdata, data1_rdata;

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_BIT(IB)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ram_index   (ram_index),
    .tag_we      (tag_we),
    .tag0_wdata  (tag0_wdata),
    .tag1_wdata  (tag1_wdata),
    .tag0_rdata  (tag0_rdata),
    .tag1_rdata  (tag1_rdata),
    .data_we     (data_we),
    .data_wdata  (data_wdata),
    .data0_rdata (data0_rdata),
    .data1_rdata (data1_rdata)
  );

  // Registered-address RAMs, zero at power-up.
  logic [22:0]   tag_ram [2][1024] = '{default: '0};
  logic [127:0]  dat_ram [2][1024] = '{default: '0};
  logic [IB-1:0] rd_idx = '0;

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (tag_we[w])  tag_ram[w][ram_index] <= (w == 0) ? tag0_wdata : tag1_wdata;
      if (data_we[w]) dat_ram[w][ram_index] <= data_wdata;
    end
    rd_idx <= ram_index;
  end

  assign tag0_rdata  = tag_ram[0][rd_idx];
  assign tag1_rdata  = tag_ram[1][rd_idx];
  assign data0_rdata = dat_ram[0][rd_idx];
  assign data1_rdata = dat_ram[1][rd_idx];

  // Backing memory seen by the DUT and architectural (golden) memory, both word addressed.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [127:0] gold_block(input logic [31:0] b);
    return {gold_rd(b + 3), gold_rd(b + 2), gold_rd(b + 1), gold_rd(b)};
  endfunction

  // Memory responder: random ack delay, logs every acknowledged transaction, stray acks when idle.
  bit           ack_block = 1'b0;
  int unsigned  wait_cnt = 0;
  logic         log_we[$];
  logic [31:0]  log_addr[$];
  logic [127:0] log_data[$];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!ack_block) begin
        if (mem_req) begin
          if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            log_we.push_back(mem_we);
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            if (mem_we) begin
              for (int k = 0; k < 4; k++) bmem[mem_addr + k] = mem_wdata[k*32 +: 32];
            end else begin
              mem_rdata = {bmem_rd(mem_addr + 3), bmem_rd(mem_addr + 2),
                           bmem_rd(mem_addr + 1), bmem_rd(mem_addr)};
            end
            wait_cnt = $urandom_range(0, 3);
          end else begin
            wait_cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Architectural 2-way model: per set, valid/used/dirty/tag/data for each way.
  bit         m_valid [2][1024];
  bit         m_used  [2][1024];
  bit         m_dirty [2][1024];
  bit [19:0]  m_tag   [2][1024];
  bit [127:0] m_data  [2][1024];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic [9:0]   idx;
    logic [19:0]  tg;
    int           way;
    bit           hit;
    bit           wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [31:0]  exp_rd;
    logic [31:0]  got_rd;
    int           cyc;
    int           exp_n;
    int           p;
    bit           done;
    idx = addr[11:2];
    tg  = addr[31:12];
    hit = 1'b0;
    way = 0;
    wb  = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    for (int w = 1; w >= 0; w--) begin
      if (m_valid[w][idx] && m_tag[w][idx] == tg) begin
        hit = 1'b1;
        way = w;
      end
    end
    if (!hit) begin
      if (!m_valid[0][idx])                          way = 0;
      else if (!m_valid[1][idx])                     way = 1;
      else if (m_used[0][idx] && !m_used[1][idx])    way = 1;
      else                                           way = 0;
      wb      = m_valid[way][idx] && m_dirty[way][idx];
      wb_addr = {m_tag[way][idx], idx, 2'b00};
      wb_data = m_data[way][idx];
    end
    exp_rd = gold_rd(addr);
    if (we) gold[addr] = wd;
    m_dirty[way][idx]   = hit ? (m_dirty[way][idx] | we) : we;
    m_valid[way][idx]   = 1'b1;
    m_tag[way][idx]     = tg;
    m_used[way][idx]    = 1'b1;
    m_used[1-way][idx]  = 1'b0;
    m_data[way][idx]    = gold_block({addr[31:2], 2'b00});

    log_we.delete();
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cyc  = 0;
    done = 1'b0;
    got_rd = '0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) begin
        done   = 1'b1;
        got_rd = cpu_rdata;
        cpu_req = 1'b0;
      end
      // Address and data changes after accept must not affect the transaction.
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
    end
    cpu_req = 1'b0;
    check_eq("done_seen", done, 1'b1);
    if (done && !we) check_eq("load_data", got_rd, exp_rd);
    if (done && hit) check_eq("hit_latency", cyc, 1);
    @(negedge clk);
    check_eq("done_pulse", cpu_done, 1'b0);
    exp_n = hit ? 0 : (wb ? 2 : 1);
    check_eq("mem_txn_count", log_we.size(), exp_n);
    if (!hit && log_we.size() == exp_n) begin
      p = 0;
      if (wb) begin
        check_eq("wb_we", log_we[0], 1'b1);
        check_eq("wb_addr", log_addr[0], wb_addr);
        check_eq("wb_data", log_data[0], wb_data);
        p = 1;
      end
      check_eq("refill_we", log_we[p], 1'b0);
      check_eq("refill_addr", log_addr[p], {addr[31:2], 2'b00});
    end
    check_eq("tag0_entry", tag_ram[0][idx], {m_valid[0][idx], m_used[0][idx], m_dirty[0][idx],
                                             m_tag[0][idx]});
    check_eq("tag1_entry", tag_ram[1][idx], {m_valid[1][idx], m_used[1][idx], m_dirty[1][idx],
                                             m_tag[1][idx]});
    check_eq("data_block", dat_ram[way][idx], m_data[way][idx]);
  endtask

  logic [31:0] ra;
  int          cyc_a;

  initial begin
    // Reset with a pending request: everything must stay quiet.
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_2FFC;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_done", cpu_done, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_tag_we", tag_we, 2'b00);
    check_eq("rst_data_we", data_we, 2'b00);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_ram_index", ram_index, 10'h0);
    cpu_req = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check_eq("idle_cpu_done", cpu_done, 1'b0);
    check_eq("idle_mem_req", mem_req, 1'b0);

    do_access(1'b0, 32'h0000_1004, 32'h0);
    check_eq("cold_tag0", tag_ram[0][1], 23'h60_0001);
    do_access(1'b0, 32'h0000_1004, 32'h0);
    do_access(1'b1, 32'h0000_1005, 32'hDEAD_BEEF);
    check_eq("store_tag0", tag_ram[0][1], 23'h70_0001);
    check_eq("store_word1", dat_ram[0][1][63:32], 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_2004, 32'h0);
    check_eq("second_fill_tag0", tag_ram[0][1], 23'h50_0001);
    do_access(1'b0, 32'h0000_3004, 32'h0);
    check_eq("third_fill_tag0", tag_ram[0][1], 23'h60_0003);

    // Reset while a refill waits for its ack: aborts with no RAM update.
    ack_block = 1'b1;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = {20'h00007, 10'd100, 2'd2};
    cyc_a = 0;
    while (!(mem_req && !mem_we) && cyc_a < 20) begin
      @(negedge clk);
      cyc_a++;
    end
    check_eq("abort_refill_seen", mem_req && !mem_we, 1'b1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("abort_mem_req", mem_req, 1'b0);
    check_eq("abort_cpu_done", cpu_done, 1'b0);
    check_eq("abort_tag_we", tag_we, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_idle_mem_req", mem_req, 1'b0);
    check_eq("abort_tag0", tag_ram[0][100], 23'h0);
    check_eq("abort_tag1", tag_ram[1][100], 23'h0);
    ack_block = 1'b0;
    do_access(1'b0, {20'h00007, 10'd100, 2'd2}, 32'h0);

    for (int i = 0; i < 250; i++) begin
      ra = {20'($urandom_range(0, 5)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
